brp_gshare: RTL and testbench

Parametrised successor to the single-table bimodal branch predictor. A table of 2-bit saturating counters is indexed either by PC alone (bimodal) or by PC XOR a speculative global history register (gshare). The block sits between IF (lookup, target generation) and EX (counter training, history repair, accuracy statistics). JAL is always predicted taken; JALR is not predicted.

---
 rtl/rv32i_types.sv | 26 ++
 rtl/sat_counter2.sv | 20 ++
 rtl/brp_gshare.sv | 131 +++++++++++++
 tb/tb_brp_gshare.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared types for the branch predictor: 2-bit counter states, prediction
// metadata carried down the pipeline, and index-mode encodings.
package rv32i_types;

    typedef logic [1:0] cnt2_t;

    localparam cnt2_t CNT_SNT = 2'b00;  // strong not-taken
    localparam cnt2_t CNT_WNT = 2'b01;  // weak not-taken (reset value)
    localparam cnt2_t CNT_WT  = 2'b10;  // weak taken
    localparam cnt2_t CNT_ST  = 2'b11;  // strong taken

    localparam int MODE_BIMODAL = 0;
    localparam int MODE_GSHARE  = 1;

    // History field is sized for the longest supported history; users keep
    // only the low HIST_BITS.
    localparam int BRP_GHR_W = 32;

    typedef struct packed {
        logic                 pred_taken;
        logic [31:0]          pred_target;
        logic [31:0]          pred_alt;
        logic [BRP_GHR_W-1:0] ghr;
    } brp_meta_t;

endpackage

// File: rtl/sat_counter2.sv
// Next-state logic for one 2-bit saturating counter.
module sat_counter2
    import rv32i_types::*;
(
    input  cnt2_t i_cnt,
    input  logic  i_taken,
    output cnt2_t o_cnt
);

    // Step toward strong-taken on taken, toward strong-not-taken otherwise.
    always_comb begin
        o_cnt = i_cnt;
        if (i_taken) begin
            if (i_cnt != CNT_ST) o_cnt = i_cnt + 2'd1;
        end else begin
            if (i_cnt != CNT_SNT) o_cnt = i_cnt - 2'd1;
        end
    end

endmodule

// File: rtl/brp_gshare.sv
// Bimodal/gshare conditional branch predictor with speculative global
// history, misprediction repair and accuracy counters.
module brp_gshare
    import rv32i_types::*;
#(
    parameter int IDX_BITS  = 8,
    parameter int HIST_BITS = 8,
    parameter int MODE      = 1,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_valid,
    input  logic                 if_is_br,
    input  logic                 if_is_jal,
    input  logic [31:0]          if_pc,
    input  logic [31:0]          if_b_imm,
    input  logic [31:0]          if_j_imm,
    output logic                 pred_taken,
    output logic [31:0]          pred_target,
    output logic [31:0]          pred_alt,
    output logic [HIST_BITS-1:0] pred_ghr,
    input  logic                 ex_valid,
    input  logic [31:0]          ex_pc,
    input  logic                 ex_taken,
    input  logic                 ex_pred_taken,
    input  logic [HIST_BITS-1:0] ex_ghr,
    output logic                 mispredict,
    output logic [CNT_W-1:0]     stat_total,
    output logic [CNT_W-1:0]     stat_correct
);

    localparam int ENTRIES = 1 << IDX_BITS;

    logic [HIST_BITS-1:0] r_ghr;
    cnt2_t                r_pht [ENTRIES];
    logic [CNT_W-1:0]     r_total;
    logic [CNT_W-1:0]     r_correct;

    logic [IDX_BITS-1:0]  w_if_idx;
    logic [IDX_BITS-1:0]  w_ex_idx;
    cnt2_t                w_ex_nxt;
    brp_meta_t            w_meta;
    logic [31:0]          w_fall;
    logic [31:0]          w_tgt;
    logic [HIST_BITS:0]   w_if_shift;
    logic [HIST_BITS:0]   w_rep_shift;

    // Zero-extending through a wide temporary covers both HIST_BITS < IDX_BITS
    // and HIST_BITS >= IDX_BITS without a parameter-dependent slice.
    function automatic logic [IDX_BITS-1:0] f_idx(input logic [31:0] pc,
                                                  input logic [HIST_BITS-1:0] h);
        logic [IDX_BITS+HIST_BITS-1:0] ext;
        ext = {{IDX_BITS{1'b0}}, h};
        if (MODE == MODE_GSHARE) return pc[IDX_BITS+1:2] ^ ext[IDX_BITS-1:0];
        else                     return pc[IDX_BITS+1:2];
    endfunction

    assign w_if_idx = f_idx(if_pc, r_ghr);
    assign w_ex_idx = f_idx(ex_pc, ex_ghr);

    sat_counter2 u_ctr (
        .i_cnt   (r_pht[w_ex_idx]),
        .i_taken (ex_taken),
        .o_cnt   (w_ex_nxt)
    );

    // Zero-latency lookup: direction from the PHT (JAL forced taken), and the
    // taken/fall-through pair ordered by the prediction.
    always_comb begin
        w_fall             = if_pc + 32'd4;
        w_tgt              = w_fall;
        w_meta.pred_taken  = 1'b0;
        w_meta.pred_target = w_fall;
        w_meta.pred_alt    = w_fall;
        w_meta.ghr         = BRP_GHR_W'(r_ghr);
        if (if_is_br) begin
            w_tgt             = if_pc + if_b_imm;
            w_meta.pred_taken = r_pht[w_if_idx][1];
        end else if (if_is_jal) begin
            w_tgt             = if_pc + if_j_imm;
            w_meta.pred_taken = 1'b1;
        end
        if (if_is_br || if_is_jal) begin
            w_meta.pred_target = w_meta.pred_taken ? w_tgt : w_fall;
            w_meta.pred_alt    = w_meta.pred_taken ? w_fall : w_tgt;
        end
    end

    assign pred_taken   = w_meta.pred_taken;
    assign pred_target  = w_meta.pred_target;
    assign pred_alt     = w_meta.pred_alt;
    assign pred_ghr     = w_meta.ghr[HIST_BITS-1:0];
    assign mispredict   = ex_valid & (ex_taken != ex_pred_taken);
    assign stat_total   = r_total;
    assign stat_correct = r_correct;

    // One-bit-wider shift temporaries also handle HIST_BITS == 1.
    assign w_if_shift  = {r_ghr, w_meta.pred_taken};
    assign w_rep_shift = {ex_ghr, ex_taken};

    // Global history: repair from EX beats the speculative IF shift (the IF
    // instruction is being flushed anyway). JAL never shifts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        r_ghr <= '0;
        else if (mispredict)            r_ghr <= w_rep_shift[HIST_BITS-1:0];
        else if (if_valid && if_is_br)  r_ghr <= w_if_shift[HIST_BITS-1:0];
    end

    // PHT training at the EX index; a same-cycle IF read sees the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) r_pht[i] <= CNT_WNT;
        end else if (ex_valid) begin
            r_pht[w_ex_idx] <= w_ex_nxt;
        end
    end

    // Accuracy counters, each saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_total   <= '0;
            r_correct <= '0;
        end else if (ex_valid) begin
            if (r_total != '1) r_total <= r_total + 1'b1;
            if ((ex_taken == ex_pred_taken) && (r_correct != '1))
                r_correct <= r_correct + 1'b1;
        end
    end

endmodule

// File: tb/tb_brp_gshare.sv
// Bench: a bimodal instance (IDX 8) and a gshare instance (IDX 4) share one
// stimulus stream and are compared against an integer-level model.
module tb_brp_gshare;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_valid = 0, if_is_br = 0, if_is_jal = 0;
    logic [31:0] if_pc = 0, if_b_imm = 0, if_j_imm = 0;
    logic        ex_valid = 0, ex_taken = 0, ex_pred_taken = 0;
    logic [31:0] ex_pc = 0;
    logic [7:0]  ex_ghr = 0;

    logic        pt  [2];
    logic [31:0] ptg [2];
    logic [31:0] pal [2];
    logic [7:0]  pgh [2];
    logic        mp  [2];
    logic [3:0]  st  [2];
    logic [3:0]  sc  [2];

    int n_chk = 0;
    int n_err = 0;

    // model state
    int m_pht [2][256];
    int m_ghr [2];
    int m_tot [2];
    int m_cor [2];

    always #5 clk = ~clk;

    brp_gshare #(.IDX_BITS(8), .HIST_BITS(8), .MODE(0), .CNT_W(4)) u_bim (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_is_br(if_is_br),
        .if_is_jal(if_is_jal), .if_pc(if_pc), .if_b_imm(if_b_imm), .if_j_imm(if_j_imm),
        .pred_taken(pt[0]), .pred_target(ptg[0]), .pred_alt(pal[0]), .pred_ghr(pgh[0]),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken),
        .ex_pred_taken(ex_pred_taken), .ex_ghr(ex_ghr), .mispredict(mp[0]),
        .stat_total(st[0]), .stat_correct(sc[0]));

    brp_gshare #(.IDX_BITS(4), .HIST_BITS(8), .MODE(1), .CNT_W(4)) u_gsh (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_is_br(if_is_br),
        .if_is_jal(if_is_jal), .if_pc(if_pc), .if_b_imm(if_b_imm), .if_j_imm(if_j_imm),
        .pred_taken(pt[1]), .pred_target(ptg[1]), .pred_alt(pal[1]), .pred_ghr(pgh[1]),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken),
        .ex_pred_taken(ex_pred_taken), .ex_ghr(ex_ghr), .mispredict(mp[1]),
        .stat_total(st[1]), .stat_correct(sc[1]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // d=0: PC bits only, 256 entries; d=1: PC word address xor history, 16 entries
    function automatic int midx(int d, logic [31:0] pc, int h);
        if (d == 0) return int'(pc >> 2) & 255;
        return (int'(pc >> 2) ^ h) & 15;
    endfunction

    function automatic int sat_add(int v, int lim);
        return (v >= lim) ? lim : v + 1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 256; i++) m_pht[d][i] = 1;
            m_ghr[d] = 0; m_tot[d] = 0; m_cor[d] = 0;
        end
    endtask

    // Expected prediction for instance d at the current inputs.
    task automatic model_pred(input int d, output logic t, output logic [31:0] tgt,
                              output logic [31:0] alt);
        logic [31:0] fall, tk;
        fall = if_pc + 32'd4;
        t = 0; tgt = fall; alt = fall;
        if (if_is_br || if_is_jal) begin
            if (if_is_br) begin
                t  = (m_pht[d][midx(d, if_pc, m_ghr[d])] >= 2);
                tk = if_pc + if_b_imm;
            end else begin
                t  = 1;
                tk = if_pc + if_j_imm;
            end
            tgt = t ? tk : fall;
            alt = t ? fall : tk;
        end
    endtask

    // Compare every output of both instances, then advance the model by the
    // clock edge that follows.
    task automatic step();
        logic t; logic [31:0] tgt, alt; logic mis;
        logic tv [2];
        @(negedge clk);
        mis = ex_valid && (ex_taken != ex_pred_taken);
        for (int d = 0; d < 2; d++) begin
            model_pred(d, t, tgt, alt);
            tv[d] = t;
            chk($sformatf("taken%0d", d),  64'(pt[d]),  64'(t));
            chk($sformatf("target%0d", d), 64'(ptg[d]), 64'(tgt));
            chk($sformatf("alt%0d", d),    64'(pal[d]), 64'(alt));
            chk($sformatf("ghr%0d", d),    64'(pgh[d]), 64'(m_ghr[d]));
            chk($sformatf("mispred%0d", d), 64'(mp[d]), 64'(mis));
            chk($sformatf("total%0d", d),  64'(st[d]),  64'(m_tot[d]));
            chk($sformatf("correct%0d", d), 64'(sc[d]), 64'(m_cor[d]));
        end
        for (int d = 0; d < 2; d++) begin
            if (ex_valid) begin
                int e;
                e = midx(d, ex_pc, int'(ex_ghr));
                if (ex_taken) m_pht[d][e] = (m_pht[d][e] == 3) ? 3 : m_pht[d][e] + 1;
                else          m_pht[d][e] = (m_pht[d][e] == 0) ? 0 : m_pht[d][e] - 1;
                m_tot[d] = sat_add(m_tot[d], 15);
                if (ex_taken == ex_pred_taken) m_cor[d] = sat_add(m_cor[d], 15);
            end
            if (mis)                        m_ghr[d] = ((int'(ex_ghr) << 1) | int'(ex_taken)) & 255;
            else if (if_valid && if_is_br)  m_ghr[d] = ((m_ghr[d] << 1) | int'(tv[d])) & 255;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        if_valid = 0; if_is_br = 0; if_is_jal = 0;
        ex_valid = 0; ex_taken = 0; ex_pred_taken = 0;
        ex_pc = 0; ex_ghr = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1; model_reset();
        #1;
        chk("rst_total", 64'(st[0]), 64'd0);
        chk("rst_correct", 64'(sc[0]), 64'd0);
        @(negedge clk); rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic train(input logic [31:0] pc, input logic [7:0] g, input logic tk);
        idle();
        ex_valid = 1; ex_pc = pc; ex_ghr = g; ex_taken = tk; ex_pred_taken = tk;
        step();
    endtask

    initial begin
        model_reset();
        #12;
        do_reset();

        // reset-state lookup of a forward branch
        idle(); if_is_br = 1; if_pc = 32'h100; if_b_imm = 32'h40;
        #1;
        chk("br0_taken", 64'(pt[0]), 64'd0);
        chk("br0_target", 64'(ptg[0]), 64'h104);
        chk("br0_alt", 64'(pal[0]), 64'h140);
        chk("br0_ghr", 64'(pgh[0]), 64'd0);
        step();

        // two taken trainings saturate the bimodal entry at strong taken
        train(32'h100, 8'h00, 1);
        train(32'h100, 8'h00, 1);
        idle(); if_is_br = 1; if_pc = 32'h100; if_b_imm = 32'h40;
        #1;
        chk("br_trained_taken", 64'(pt[0]), 64'd1);
        chk("br_trained_target", 64'(ptg[0]), 64'h140);
        step();

        // JAL: always taken, history untouched
        idle(); if_valid = 1; if_is_jal = 1; if_pc = 32'h200; if_j_imm = 32'hFFFF_FFF8;
        #1;
        chk("jal_target", 64'(ptg[0]), 64'h1F8);
        chk("jal_alt", 64'(pal[0]), 64'h204);
        step();
        chk("jal_ghr", 64'(pgh[0]), 64'd0);

        // set GHR to 0000_0101 by repair, then repair again against an IF shift
        idle(); ex_valid = 1; ex_pc = 32'h300; ex_ghr = 8'h02; ex_taken = 1; ex_pred_taken = 0;
        step();
        chk("ghr_0101", 64'(pgh[0]), 64'h05);
        idle(); if_valid = 1; if_is_br = 1; if_pc = 32'h100; if_b_imm = 32'h40;
        ex_valid = 1; ex_pc = 32'h300; ex_ghr = 8'h02; ex_taken = 1; ex_pred_taken = 0;
        #1;
        chk("rep_if_taken", 64'(pt[0]), 64'd1);
        chk("rep_mispredict", 64'(mp[0]), 64'd1);
        step();
        chk("rep_ghr", 64'(pgh[0]), 64'h05);

        // three not-taken trainings and one more hold at strong not-taken
        for (int i = 0; i < 4; i++) train(32'h100, 8'h00, 0);
        idle(); if_is_br = 1; if_pc = 32'h100; if_b_imm = 32'h40;
        step();
        train(32'h100, 8'h00, 1);
        idle(); if_is_br = 1; if_pc = 32'h100;
        #1;
        chk("nt_saturated", 64'(pt[0]), 64'd0);
        step();

        // gshare aliasing: pc 0x40 with ghr 0 vs 1 maps to entries 0 and 1
        do_reset();
        train(32'h40, 8'h00, 1);
        train(32'h40, 8'h00, 1);
        idle(); if_is_br = 1; if_pc = 32'h40;
        #1;
        chk("gsh_h0_taken", 64'(pt[1]), 64'd1);
        step();
        idle(); ex_valid = 1; ex_pc = 32'h48; ex_ghr = 8'h00; ex_taken = 1; ex_pred_taken = 0;
        step();
        idle(); if_is_br = 1; if_pc = 32'h40;
        #1;
        chk("gsh_h1_ghr", 64'(pgh[1]), 64'd1);
        chk("gsh_h1_taken", 64'(pt[1]), 64'd0);
        step();

        // statistics: 20 resolved, 12 correct
        do_reset();
        for (int i = 0; i < 20; i++) begin
            idle(); ex_valid = 1; ex_pc = 32'h500; ex_taken = 1;
            ex_pred_taken = (i < 12) ? 1'b1 : 1'b0;
            step();
        end
        idle();
        #1;
        chk("stat_total_sat", 64'(st[0]), 64'd15);
        chk("stat_correct", 64'(sc[0]), 64'd12);
        // asynchronous reset mid-cycle
        #2 rst = 1;
        #1;
        chk("midrst_total", 64'(st[1]), 64'd0);
        chk("midrst_correct", 64'(sc[1]), 64'd0);
        chk("midrst_ghr", 64'(pgh[0]), 64'd0);
        model_reset();
        @(negedge clk); rst = 0;
        @(posedge clk); #1;

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [1:0] kind;
            kind      = 2'($urandom_range(0, 3));
            if_valid  = 1'($urandom);
            if_is_br  = (kind <= 1);
            if_is_jal = (kind == 2);
            if_pc     = 32'h1000 + {24'($urandom_range(0, 63)), 2'b00};
            if_b_imm  = 32'($signed(13'($urandom) & 13'h1FFE));
            if_j_imm  = 32'($signed(21'($urandom) & 21'h1FFFFE));
            ex_valid  = 1'($urandom);
            ex_pc     = 32'h1000 + {24'($urandom_range(0, 63)), 2'b00};
            ex_taken  = 1'($urandom);
            ex_pred_taken = ($urandom_range(0, 3) != 0) ? ex_taken : ~ex_taken;
            ex_ghr    = 8'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
